conv3x3_stream: RTL and testbench

Parametrised streaming 3x3 Sobel convolution engine for the camera gray-scale path. It is the successor to the fixed vertical-edge filter. It adds:
- internal two-line buffering sized by parameter;
- run-time mode selection: Gx, Gy, |Gx|+|Gy| magnitude, or bypass;
- frame/line position tracking with valid-window gating;
- saturating output.

It sits after the RAW-to-gray conversion and feeds the display/VGA pixel mux.

---
 rtl/conv3x3_stream_if.sv | 25 ++
 rtl/conv3x3_stream.sv | 183 ++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// Pixel-stream bundle for conv3x3_stream: gray pixels in, filtered pixels with window coordinates out.
// The master drives the input stream and the slave (the filter) drives the results.
interface conv3x3_stream_if #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 12
);
    logic [DATA_W-1:0] iDATA;
    logic              iDVAL;
    logic              iSOF;
    logic [1:0]        iMODE;
    logic [OUT_W-1:0]  oDATA;
    logic              oDVAL;
    logic [10:0]       oX;
    logic [10:0]       oY;

    modport master (
        output iDATA, iDVAL, iSOF, iMODE,
        input  oDATA, oDVAL, oX, oY
    );

    modport slave (
        input  iDATA, iDVAL, iSOF, iMODE,
        output oDATA, oDVAL, oX, oY
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Sobel engine (Gx, Gy, |Gx|+|Gy|, bypass) with two internal line buffers,
// raster position tracking, border suppression and a saturating output.
module conv3x3_stream #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640,
    parameter int OUT_W  = 12
) (
    input logic             iCLK,
    input logic             iRST,
    conv3x3_stream_if.slave pixBus
);
    localparam int SW = DATA_W + 4;
    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [10:0] LAST_COL = 11'(LINE_W - 1);
    localparam logic [SW+OUT_W-1:0] SAT_MAX = {{SW{1'b0}}, {OUT_W{1'b1}}};

    typedef logic signed [SW-1:0] sum_t;

    function automatic sum_t pix(input logic [DATA_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    function automatic logic [SW-1:0] absVal(input sum_t v);
        logic [SW-1:0] u;
        u = v;
        return v[SW-1] ? (~u + SW'(1)) : u;
    endfunction

    function automatic logic [OUT_W-1:0] satOut(input logic [SW-1:0] v);
        logic [SW+OUT_W-1:0] wide;
        wide = {{OUT_W{1'b0}}, v};
        if (wide > SAT_MAX) return {OUT_W{1'b1}};
        return wide[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] fitOut(input logic [DATA_W-1:0] v);
        logic [DATA_W+OUT_W-1:0] wide;
        wide = {{OUT_W{1'b0}}, v};
        return wide[OUT_W-1:0];
    endfunction

    logic              accept;
    logic [10:0]       colCnt, rowCnt;
    logic [10:0]       curCol, curRow, nxtCol, nxtRow;
    logic [1:0]        modeLat;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] lineA [LINE_W];
    logic [DATA_W-1:0] lineB [LINE_W];
    logic [DATA_W-1:0] rdA, rdB;

    logic [DATA_W-1:0] win_p0 [3][3];
    logic              vld_p0;
    logic [1:0]        mode_p0;
    logic [10:0]       x_p0, y_p0;

    sum_t              gxC, gyC;
    sum_t              gx_p1, gy_p1;
    logic [DATA_W-1:0] ctr_p1;
    logic              vld_p1;
    logic [1:0]        mode_p1;
    logic [10:0]       x_p1, y_p1;

    logic [SW-1:0]     absX, absY;
    logic [OUT_W-1:0]  resC;
    logic [OUT_W-1:0]  outData;
    logic              outVld;
    logic [10:0]       outX, outY;

    assign accept = pixBus.iDVAL;

    // A start-of-frame pixel is position (0,0) no matter where the counters stood.
    always_comb begin
        curCol = pixBus.iSOF ? 11'd0 : colCnt;
        curRow = pixBus.iSOF ? 11'd0 : rowCnt;
        nxtCol = curCol + 11'd1;
        nxtRow = curRow;
        if (curCol == LAST_COL) begin
            nxtCol = 11'd0;
            nxtRow = (curRow == 11'h7FF) ? curRow : curRow + 11'd1;
        end
    end

    assign addr = curCol[AW-1:0];
    assign rdA  = lineA[addr];
    assign rdB  = lineB[addr];

    always_ff @(posedge iCLK) begin
        if (!iRST && accept) begin
            lineA[addr] <= pixBus.iDATA;
            lineB[addr] <= rdA;
        end
    end

    // Stage p0: position tracking and 3x3 window shift
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            colCnt  <= '0;
            rowCnt  <= '0;
            modeLat <= 2'b00;
            vld_p0  <= 1'b0;
            mode_p0 <= 2'b00;
            x_p0    <= '0;
            y_p0    <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p0[r][c] <= '0;
        end else begin
            vld_p0 <= accept && (curRow >= 11'd2) && (curCol >= 11'd2);
            if (accept) begin
                colCnt  <= nxtCol;
                rowCnt  <= nxtRow;
                if (pixBus.iSOF) modeLat <= pixBus.iMODE;
                mode_p0 <= pixBus.iSOF ? pixBus.iMODE : modeLat;
                x_p0    <= curCol - 11'd1;
                y_p0    <= curRow - 11'd1;
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= rdB;
                win_p0[1][2] <= rdA;
                win_p0[2][2] <= pixBus.iDATA;
            end
        end
    end

    always_comb begin
        gxC = (pix(win_p0[0][2]) + (pix(win_p0[1][2]) <<< 1) + pix(win_p0[2][2]))
            - (pix(win_p0[0][0]) + (pix(win_p0[1][0]) <<< 1) + pix(win_p0[2][0]));
        gyC = (pix(win_p0[2][0]) + (pix(win_p0[2][1]) <<< 1) + pix(win_p0[2][2]))
            - (pix(win_p0[0][0]) + (pix(win_p0[0][1]) <<< 1) + pix(win_p0[0][2]));
    end

    // Stage p1: signed gradients
    always_ff @(posedge iCLK) begin
        if (iRST) vld_p1 <= 1'b0;
        else      vld_p1 <= vld_p0;
    end

    always_ff @(posedge iCLK) begin
        gx_p1   <= gxC;
        gy_p1   <= gyC;
        ctr_p1  <= win_p0[1][1];
        mode_p1 <= mode_p0;
        x_p1    <= x_p0;
        y_p1    <= y_p0;
    end

    assign absX = absVal(gx_p1);
    assign absY = absVal(gy_p1);

    always_comb begin
        resC = '0;
        case (mode_p1)
            2'b00:   resC = satOut(absX);
            2'b01:   resC = satOut(absY);
            2'b10:   resC = satOut(absX + absY);
            default: resC = fitOut(ctr_p1);
        endcase
    end

    // Stage p2: registered output, held while no new result arrives
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            outVld  <= 1'b0;
            outData <= '0;
            outX    <= '0;
            outY    <= '0;
        end else begin
            outVld <= vld_p1;
            if (vld_p1) begin
                outData <= resC;
                outX    <= x_p1;
                outY    <= y_p1;
            end
        end
    end

    assign pixBus.oDATA = outData;
    assign pixBus.oDVAL = outVld;
    assign pixBus.oX    = outX;
    assign pixBus.oY    = outY;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed and randomized frames for conv3x3_stream, scored against a kernel-sum model of the image.
module tb_conv3x3_stream;
    localparam int LW = 8;
    localparam int H = 8;
    localparam int DW = 12;
    localparam int OW = 12;
    localparam int MAXO = 4095;
    localparam int KX[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KY[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    conv3x3_stream_if #(.DATA_W(DW), .OUT_W(OW)) pixBus ();

    conv3x3_stream #(.DATA_W(DW), .LINE_W(LW), .OUT_W(OW)) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .pixBus(pixBus)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int obsN = 0;
    int obsData[2048];
    int obsX[2048];
    int obsY[2048];
    int obsCyc[2048];

    always @(negedge iCLK) begin
        if (pixBus.oDVAL === 1'b1) begin
            if (obsN < 2048) begin
                obsData[obsN] <= int'(pixBus.oDATA);
                obsX[obsN]    <= int'(pixBus.oX);
                obsY[obsN]    <= int'(pixBus.oY);
                obsCyc[obsN]  <= cyc;
            end
            obsN <= obsN + 1;
        end
    end

    int total = 0;
    int bad = 0;
    int img[H][LW];
    int driveCyc[H][LW];
    int expData[64];
    int expX[64];
    int expY[64];
    int expN = 0;
    int rdIdx = 0;
    int nzSeen = 0;
    int maxSeen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic setImg(input int kind, input int lo, input int hi);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < LW; x++)
                case (kind)
                    0: img[y][x] = hi;
                    1: img[y][x] = (x >= 4) ? hi : lo;
                    2: img[y][x] = (y >= 4) ? hi : lo;
                    3: img[y][x] = (x >= y) ? hi : lo;
                    default: img[y][x] = int'($urandom_range(0, MAXO));
                endcase
    endtask

    // Every interior pixel yields one result, in raster order of the window centre.
    task automatic buildExp(input int mode);
        int gx, gy, v;
        expN = 0;
        for (int y = 1; y < H - 1; y++)
            for (int x = 1; x < LW - 1; x++) begin
                gx = 0;
                gy = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        gx += KX[i][j] * img[y - 1 + i][x - 1 + j];
                        gy += KY[i][j] * img[y - 1 + i][x - 1 + j];
                    end
                if (gx < 0) gx = -gx;
                if (gy < 0) gy = -gy;
                case (mode)
                    0: v = gx;
                    1: v = gy;
                    2: v = gx + gy;
                    default: v = img[y][x];
                endcase
                if (v > MAXO) v = MAXO;
                expData[expN] = v;
                expX[expN] = x;
                expY[expN] = y;
                expN++;
            end
    endtask

    task automatic runFrame(input int mode, input int gap, input int switchAt,
                            input int lim, input int rstAt, input string tag);
        int x, y;
        for (int p = 0; p < lim; p++) begin
            y = p / LW;
            x = p % LW;
            pixBus.iDVAL = 1'b0;
            pixBus.iSOF = 1'b0;
            if (gap == 1) tick();
            if (gap == 2 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
            pixBus.iDATA = DW'(img[y][x]);
            pixBus.iDVAL = 1'b1;
            pixBus.iSOF = (p == 0);
            if (p == 0) pixBus.iMODE = 2'(mode);
            else if (switchAt >= 0) pixBus.iMODE = (p >= switchAt) ? 2'(mode ^ 1) : 2'(mode);
            else pixBus.iMODE = 2'($urandom_range(0, 3));
            driveCyc[y][x] = cyc;
            if (p == rstAt) iRST = 1'b1;
            tick();
            if (p == rstAt) begin
                pixBus.iDVAL = 1'b0;
                check({tag, ".oDVAL"}, 32'(pixBus.oDVAL), 0);
                check({tag, ".oDATA"}, 32'(pixBus.oDATA), 0);
                check({tag, ".oX"}, 32'(pixBus.oX), 0);
                check({tag, ".oY"}, 32'(pixBus.oY), 0);
                iRST = 1'b0;
                return;
            end
        end
        pixBus.iDVAL = 1'b0;
        pixBus.iSOF = 1'b0;
    endtask

    task automatic endFrame(input string tag);
        int n, k;
        repeat (6) tick();
        n = obsN - rdIdx;
        check({tag, ".count"}, n, expN);
        nzSeen = 0;
        maxSeen = 0;
        for (int i = 0; i < expN && i < n; i++) begin
            k = rdIdx + i;
            if (k < 2048) begin
                check($sformatf("%s.data[%0d]", tag, i), obsData[k], expData[i]);
                check($sformatf("%s.x[%0d]", tag, i), obsX[k], expX[i]);
                check($sformatf("%s.y[%0d]", tag, i), obsY[k], expY[i]);
                check($sformatf("%s.lat[%0d]", tag, i), obsCyc[k],
                      driveCyc[expY[i] + 1][expX[i] + 1] + 3);
            end
        end
        for (int i = 0; i < n; i++) begin
            k = rdIdx + i;
            if (k < 2048) begin
                if (obsData[k] != 0) nzSeen++;
                if (obsData[k] > maxSeen) maxSeen = obsData[k];
            end
        end
        rdIdx = obsN;
    endtask

    initial begin
        pixBus.iDATA = '0;
        pixBus.iDVAL = 1'b0;
        pixBus.iSOF = 1'b0;
        pixBus.iMODE = 2'b00;
        iRST = 1'b1;
        repeat (3) tick();
        check("reset.oDVAL", 32'(pixBus.oDVAL), 0);
        check("reset.oDATA", 32'(pixBus.oDATA), 0);
        check("reset.oX", 32'(pixBus.oX), 0);
        check("reset.oY", 32'(pixBus.oY), 0);
        iRST = 1'b0;
        tick();

        setImg(0, 0, 100);
        buildExp(0);
        runFrame(0, 0, -1, 64, -1, "flat");
        endFrame("flat");
        check("flat.nz", nzSeen, 0);

        setImg(1, 0, 100);
        buildExp(0);
        runFrame(0, 0, -1, 64, -1, "vstepGx");
        endFrame("vstepGx");
        check("vstepGx.nz", nzSeen, 12);
        check("vstepGx.max", maxSeen, 400);
        buildExp(1);
        runFrame(1, 0, -1, 64, -1, "vstepGy");
        endFrame("vstepGy");
        check("vstepGy.nz", nzSeen, 0);

        setImg(2, 0, 100);
        buildExp(1);
        runFrame(1, 0, -1, 64, -1, "hstepGy");
        endFrame("hstepGy");
        check("hstepGy.nz", nzSeen, 12);
        check("hstepGy.max", maxSeen, 400);
        setImg(3, 0, 100);
        buildExp(2);
        runFrame(2, 0, -1, 64, -1, "diagMag");
        endFrame("diagMag");

        setImg(1, 0, 4095);
        buildExp(0);
        runFrame(0, 0, -1, 64, -1, "satGx");
        endFrame("satGx");
        check("satGx.nz", nzSeen, 12);
        check("satGx.max", maxSeen, 4095);
        buildExp(2);
        runFrame(2, 0, -1, 64, -1, "satMag");
        endFrame("satMag");
        check("satMag.max", maxSeen, 4095);

        setImg(4, 0, 0);
        for (int m = 0; m < 4; m++) begin
            buildExp(m);
            runFrame(m, 0, -1, 64, -1, $sformatf("rnd%0d", m));
            endFrame($sformatf("rnd%0d", m));
        end
        buildExp(2);
        runFrame(2, 1, -1, 64, -1, "gapAlt");
        endFrame("gapAlt");
        runFrame(2, 2, -1, 64, -1, "gapRnd");
        endFrame("gapRnd");

        setImg(1, 0, 100);
        buildExp(0);
        runFrame(0, 0, 10, 64, -1, "modeHold");
        endFrame("modeHold");
        check("modeHold.nz", nzSeen, 12);
        check("modeHold.max", maxSeen, 400);

        setImg(4, 0, 0);
        expN = 0;
        runFrame(0, 0, -1, 13, -1, "partial");
        endFrame("partial");
        setImg(1, 0, 100);
        buildExp(0);
        runFrame(0, 0, -1, 64, -1, "afterSof");
        endFrame("afterSof");

        expN = 0;
        runFrame(0, 0, -1, 21, 20, "rstMid");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rstMid.idle%0d", i), 32'(pixBus.oDVAL), 0);
            tick();
        end
        endFrame("rstMid");
        buildExp(0);
        runFrame(0, 0, -1, 64, -1, "afterRst");
        endFrame("afterRst");
        check("afterRst.nz", nzSeen, 12);
        check("afterRst.max", maxSeen, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
